// File: rtl/ps2_pkg.sv
// Shared constants, drop list and frame FSM encoding for the PS/2 scan-code receiver.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Device responses and overrun codes that never produce a key event.
    localparam logic [7:0] PS2_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_OVR_LO = 8'h00;
    localparam logic [7:0] PS2_OVR_HI = 8'hFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    function automatic logic is_drop(input logic [7:0] code);
        return (code == PS2_BAT_OK) || (code == PS2_ACK)    || (code == PS2_ECHO) ||
               (code == PS2_RESEND) || (code == PS2_OVR_LO) || (code == PS2_OVR_HI);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter for one PS/2 pin.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with level;
    // level flips on the FILTER_LEN-th such sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_LEN - 1)) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 Set-2 receiver: frame FSM, inter-edge timeout and prefix-folding byte decoder
// producing a toggle-strobed {toggle, pressed, ext, code} key bus.
module ps2_scancode_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic        CLKSYS,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [10:0] ps2_key,
    output logic        FRAME_ERR,
    output logic [1:0]  frame_state
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_f;
    logic          dat_f;
    logic          clk_prev;
    logic          fall;
    frame_state_t  state;
    frame_state_t  state_next;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par;
    logic [TW-1:0] to_cnt;
    logic          take_bit;
    logic          take_par;
    logic          byte_ok;
    logic          err;
    logic          ext;
    logic          brk;
    logic [2:0]    skip;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (CLKSYS),
        .rst   (RESET),
        .raw   (PS2_CLK),
        .level (clk_f)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .clk   (CLKSYS),
        .rst   (RESET),
        .raw   (PS2_DAT),
        .level (dat_f)
    );

    assign fall        = clk_prev & ~clk_f;
    assign frame_state = state;

    always_comb begin
        state_next = state;
        take_bit   = 1'b0;
        take_par   = 1'b0;
        byte_ok    = 1'b0;
        err        = 1'b0;
        case (state)
            IDLE: begin
                if (fall && !dat_f) state_next = DATA;
            end
            DATA: begin
                if (fall) begin
                    take_bit = 1'b1;
                    if (bit_cnt == 3'd7) state_next = PARITY;
                end
            end
            PARITY: begin
                if (fall) begin
                    take_par   = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (dat_f && (^{shift, par})) byte_ok = 1'b1;
                    else                          err     = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // A falling edge in the expiry cycle takes priority over the abort.
        if ((state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
            err        = 1'b1;
            state_next = IDLE;
        end
    end

    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            clk_prev  <= 1'b1;
            bit_cnt   <= '0;
            shift     <= '0;
            par       <= 1'b0;
            to_cnt    <= '0;
            FRAME_ERR <= 1'b0;
        end else begin
            state     <= state_next;
            clk_prev  <= clk_f;
            FRAME_ERR <= err;
            if (fall || (state == IDLE)) to_cnt <= '0;
            else                         to_cnt <= to_cnt + 1'b1;
            if (state == IDLE) bit_cnt <= '0;
            if (take_bit) begin
                shift   <= {dat_f, shift[7:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
            if (take_par) par <= dat_f;
        end
    end

    always_ff @(posedge CLKSYS or posedge RESET) begin
        if (RESET) begin
            ps2_key <= '0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else if (err) begin
            ext <= 1'b0;
            brk <= 1'b0;
        end else if (byte_ok) begin
            if (skip != 3'd0) begin
                skip <= skip - 1'b1;
            end else if (shift == PS2_EXT) begin
                ext <= 1'b1;
            end else if (shift == PS2_BRK) begin
                brk <= 1'b1;
            end else if (shift == PS2_PAUSE) begin
                skip <= PAUSE_SKIP;
                ext  <= 1'b0;
                brk  <= 1'b0;
            end else if (is_drop(shift)) begin
                ext <= 1'b0;
                brk <= 1'b0;
            end else begin
                ps2_key <= {~ps2_key[10], ~brk, ext, shift};
                ext     <= 1'b0;
                brk     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx: bit-banged PS/2 frames, event scoreboard and
// FRAME_ERR pulse monitor.
module tb_ps2_scancode_rx;

    localparam int FL   = 4;
    localparam int TO   = 1000;
    localparam int HALF = 80;

    logic        clk;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_dat;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic [1:0]  frame_state;

    logic [10:0] exp_q[$];
    int          n_checks;
    int          n_pass;
    int          ev_cnt;
    int          err_cnt;
    int          err_run;
    int          bad_change;

    ps2_scancode_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
        .CLKSYS      (clk),
        .RESET       (rst),
        .PS2_CLK     (ps2_clk),
        .PS2_DAT     (ps2_dat),
        .ps2_key     (ps2_key),
        .FRAME_ERR   (frame_err),
        .frame_state (frame_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        repeat (95000) @(posedge clk);
        $display("FAIL watchdog: got no finish, expected finish before 95000 cycles");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends frame[0] .. frame[nbits-1], one bit per PS/2 clock low pulse.
    task automatic send_frame(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = frame[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input logic bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        send_frame(make_frame(b, bad_par), 11);
        tick(2 * HALF);
    endtask

    // Scoreboard and FRAME_ERR monitor, sampled on the falling clock edge.
    initial begin : monitor
        logic [10:0] prev_key;
        logic [1:0]  prev_state;
        logic [10:0] exp_key;
        prev_key   = '0;
        prev_state = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_key   = ps2_key;
                prev_state = frame_state;
                err_run    = 0;
            end else begin
                if (ps2_key != prev_key) begin
                    if (ps2_key[10] == prev_key[10]) begin
                        bad_change++;
                    end else begin
                        ev_cnt++;
                        check("event_latency_prev_state", 32'(prev_state), 32'd3);
                        if (exp_q.size() == 0) begin
                            check("spurious_event", 32'(ps2_key), 32'(prev_key));
                        end else begin
                            exp_key = exp_q.pop_front();
                            check("event_key", 32'(ps2_key), 32'(exp_key));
                        end
                    end
                end
                if (frame_err) begin
                    err_run++;
                    if (err_run == 1) err_cnt++;
                end else if (err_run != 0) begin
                    check("frame_err_width", 32'(err_run), 32'd1);
                    err_run = 0;
                end
                prev_key   = ps2_key;
                prev_state = frame_state;
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_pass     = 0;
        ev_cnt     = 0;
        err_cnt    = 0;
        err_run    = 0;
        bad_change = 0;
        rst        = 1'b1;
        ps2_clk    = 1'b1;
        ps2_dat    = 1'b1;
        tick(5);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_state", 32'(frame_state), 32'h0);
        rst = 1'b0;
        tick(20);

        // Plain make code.
        exp_q.push_back(11'h61C);
        send_byte(8'h1C, 1'b0);
        check("press_1c_key", 32'(ps2_key), 32'h61C);
        check("press_1c_events", 32'(ev_cnt), 32'd1);

        // Break prefix alone must not move the bus.
        send_byte(8'hF0, 1'b0);
        check("f0_alone_key", 32'(ps2_key), 32'h61C);
        check("f0_alone_events", 32'(ev_cnt), 32'd1);
        exp_q.push_back(11'h01C);
        send_byte(8'h1C, 1'b0);
        check("release_1c_key", 32'(ps2_key), 32'h01C);

        // Extended press, then extended release.
        exp_q.push_back(11'h775);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_press_75", 32'(ps2_key), 32'h775);
        exp_q.push_back(11'h175);
        send_byte(8'hE0, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h75, 1'b0);
        check("ext_release_75", 32'(ps2_key), 32'h175);
        check("ext_events", 32'(ev_cnt), 32'd4);

        // Parity error after E0 must clear ext.
        exp_q.push_back(11'h675);
        send_byte(8'hE0, 1'b0);
        send_byte(8'h1C, 1'b1);
        check("parity_err_count", 32'(err_cnt), 32'd1);
        check("parity_err_key_held", 32'(ps2_key), 32'h175);
        send_byte(8'h75, 1'b0);
        check("after_err_75", 32'(ps2_key), 32'h675);

        // Pause sequence swallowed, then one normal press.
        send_byte(8'hE1, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'h77, 1'b0);
        send_byte(8'hE1, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h77, 1'b0);
        check("pause_no_event", 32'(ev_cnt), 32'd5);
        check("pause_key_held", 32'(ps2_key), 32'h675);
        exp_q.push_back(11'h229);
        send_byte(8'h29, 1'b0);
        check("after_pause_29", 32'(ps2_key), 32'h229);

        // Clock stalls after four data bits.
        send_frame(make_frame(8'h1C, 1'b0), 5);
        check("stall_in_frame", 32'(frame_state), 32'd1);
        tick(TO + 200);
        check("timeout_err_count", 32'(err_cnt), 32'd2);
        check("timeout_idle", 32'(frame_state), 32'd0);
        exp_q.push_back(11'h61C);
        send_byte(8'h1C, 1'b0);
        check("after_timeout_1c", 32'(ps2_key), 32'h61C);

        // Short low glitch on the clock with data low looks like a start bit if sampled.
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        tick(3);
        ps2_clk = 1'b1;
        tick(20);
        check("glitch_idle", 32'(frame_state), 32'd0);
        ps2_dat = 1'b1;
        tick(20);
        exp_q.push_back(11'h233);
        send_byte(8'h33, 1'b0);
        check("after_glitch_33", 32'(ps2_key), 32'h233);
        check("after_glitch_err", 32'(err_cnt), 32'd2);

        // Reset in the middle of a frame.
        send_frame(make_frame(8'h5A, 1'b0), 6);
        rst = 1'b1;
        tick(3);
        check("midreset_key", 32'(ps2_key), 32'h0);
        check("midreset_state", 32'(frame_state), 32'd0);
        rst = 1'b0;
        tick(TO + 200);
        check("post_reset_key", 32'(ps2_key), 32'h0);
        check("post_reset_events", 32'(ev_cnt), 32'd8);
        check("post_reset_err", 32'(err_cnt), 32'd2);
        exp_q.push_back(11'h65A);
        send_byte(8'h5A, 1'b0);
        check("post_reset_5a", 32'(ps2_key), 32'h65A);

        tick(10);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("low_bits_only_with_toggle", 32'(bad_change), 32'd0);
        check("total_events", 32'(ev_cnt), 32'd9);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
